// File: rtl/instruction_fetch_unit.sv
// Purpose : decoupled fetch stage; owns the fetch PC, reads imem over req/ack, buffers {instr,pc}.
// Latency : ack edge -> if_valid next cycle (registered FIFO); 0 cycles with IFU_BYPASS_EN defined.
// Backpr. : if_ready=0 fills the prefetch FIFO; no new request is issued once it would be full.
// Optional feature macro: IFU_BYPASS_EN (empty-FIFO combinational bypass of the returning word).
module instruction_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  fetch_entry_t   fifo_mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  logic [31:0]    fetch_pc;
  logic [31:0]    fetch_pc_next;
  logic [31:0]    addr_next;
  logic           req_next;
  logic           drop_pending;
  logic           drop_next;
  logic           accept;
  logic           req_stays;
  logic           take;
  logic           head_valid;
  logic           byp_valid;
  logic           fifo_push;
  logic           fifo_pop;

  // Only the word-aligned part of the redirect target is meaningful.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Handshake decode: what happens to the returning word and the FIFO head this cycle.
  always_comb begin
    accept     = imem_req && imem_ack;
    req_stays  = imem_req && !imem_ack;
    // A word is kept only if it belongs to the current stream and no redirect kills it.
    take       = accept && !drop_pending && !redirect;
    head_valid = (count != '0);
`ifdef IFU_BYPASS_EN
    // Empty FIFO: present the returning word directly to decode.
    byp_valid  = take && !head_valid;
`else
    byp_valid  = 1'b0;
`endif
    fifo_pop   = head_valid && if_ready && !redirect;
    // A bypassed word consumed in its ack cycle never enters the FIFO.
    fifo_push  = take && !(byp_valid && if_ready);
  end

  // Next-state for fetch PC, occupancy, drop flag and the request register.
  always_comb begin
    count_next    = count;
    fetch_pc_next = fetch_pc;
    if (redirect) begin
      count_next    = '0;
      fetch_pc_next = {redirect_pc[31:2], 2'b00};
    end else begin
      count_next = count + CW'(fifo_push) - CW'(fifo_pop);
      if (take) begin
        fetch_pc_next = imem_addr + 32'd4;
      end
    end
    // An outstanding request cannot be cancelled, so its data is marked for discard instead.
    drop_next = req_stays && (drop_pending || redirect);
    req_next  = req_stays || (count_next < CW'(DEPTH));
    addr_next = req_stays ? imem_addr : fetch_pc_next;
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc     <= RESET_PC;
      count        <= '0;
      drop_pending <= 1'b0;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
    end else begin
      fetch_pc     <= fetch_pc_next;
      count        <= count_next;
      drop_pending <= drop_next;
      imem_req     <= req_next;
      imem_addr    <= addr_next;
    end
  end

  // FIFO pointers; a redirect empties the FIFO by rewinding both.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= {imem_rdata, imem_addr};
    end
  end

  // Downstream outputs, forced to zero while nothing is valid.
  always_comb begin
    if_valid = head_valid || byp_valid;
    if_instr = '0;
    if_pc    = '0;
    if (head_valid) begin
      if_instr = fifo_mem[rd_ptr].instr;
      if_pc    = fifo_mem[rd_ptr].pc;
    end else if (byp_valid) begin
      if_instr = imem_rdata;
      if_pc    = imem_addr;
    end
  end

  assign if_pc_plus4 = if_valid ? (if_pc + 32'd4) : 32'd0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  logic        w_rst_n;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_plus4;

  int total = 0;
  int bad   = 0;
  int mem_wait = 0;
  int wait_cnt = 0;

  localparam logic [31:0] XK = 32'hA5A5_A5A5;

  always #5 clock = ~clock;

  // Instruction memory model: ack after mem_wait wait cycles, data = addr ^ XK.
  assign imem_ack   = imem_req && (wait_cnt >= mem_wait);
  assign imem_rdata = imem_addr ^ XK;
  always @(posedge clock) wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;

  // Second instance for the address wrap case, zero-wait memory.
  assign w_rdata = w_addr ^ XK;

  instruction_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  instruction_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clock(clock), .reset_n(w_rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(w_rdata),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .if_valid(w_valid), .if_ready(w_ready), .if_instr(w_instr),
    .if_pc(w_pc), .if_pc_plus4(w_plus4)
  );

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL pre_reset_req got=%h exp=1", imem_req); end
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%h exp=1", if_valid); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%h exp=0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%h exp=0", if_valid); end
    total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", if_instr); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", if_pc); end
    total++; if (if_pc_plus4 !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h exp=0", if_pc_plus4); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_backpressure();
    if_ready = 1'b0;
    @(negedge clock);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL bp_first_req got=%h/%h exp=1/0", imem_req, imem_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL bp_no_early_valid got=%h exp=0", if_valid); end
    @(negedge clock);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL bp_first_word got=%h/%h exp=1/0", if_valid, if_pc); end
    total++; if (if_instr !== XK) begin bad++; $display("FAIL bp_first_instr got=%h exp=%h", if_instr, XK); end
    repeat (2) @(negedge clock);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin bad++; $display("FAIL bp_fourth_req got=%h/%h exp=1/c", imem_req, imem_addr); end
    @(negedge clock);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_full_stop got=%h exp=0", imem_req); end
    @(negedge clock);
    total++; if (imem_req !== 1'b0 || if_pc !== 32'h0) begin bad++; $display("FAIL bp_hold got=%h/%h exp=0/0", imem_req, if_pc); end
    if_ready = 1'b1;
    @(negedge clock);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin bad++; $display("FAIL bp_resume got=%h/%h exp=1/10", imem_req, imem_addr); end
    total++; if (if_pc !== 32'h4) begin bad++; $display("FAIL bp_after_pop got=%h exp=4", if_pc); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clock);
    redirect = 1'b0;
    total++; if (if_valid !== 1'b0 || imem_addr !== 32'h40 || imem_req !== 1'b1) begin bad++; $display("FAIL st_redirect got=%h/%h/%h exp=0/40/1", if_valid, imem_addr, imem_req); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      exp_pc = 32'h40 + 32'(4 * i);
      total++; if (if_valid !== 1'b1 || if_pc !== exp_pc) begin bad++; $display("FAIL st_pc[%0d] got=%h/%h exp=1/%h", i, if_valid, if_pc, exp_pc); end
      total++; if (if_pc_plus4 !== exp_pc + 32'd4 || if_instr !== (exp_pc ^ XK)) begin bad++; $display("FAIL st_data[%0d] got=%h/%h exp=%h/%h", i, if_pc_plus4, if_instr, exp_pc + 32'd4, exp_pc ^ XK); end
    end
  endtask

  task automatic test_redirect_outstanding();
    int n;
    mem_wait = 3;
    if_ready = 1'b1;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr === 32'h8) && n < 40) begin
      @(negedge clock);
      n++;
    end
    total++; if (n >= 40) begin bad++; $display("FAIL ro_reach_8 got=%h exp=8", imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clock);
    redirect = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_valid !== 1'b0) begin bad++; $display("FAIL ro_hold got=%h/%h/%h exp=1/8/0", imem_req, imem_addr, if_valid); end
    repeat (3) @(negedge clock);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin bad++; $display("FAIL ro_target_req got=%h/%h/%h exp=1/100/0", imem_req, imem_addr, if_valid); end
    n = 0;
    while (if_valid !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    total++; if (n !== 4) begin bad++; $display("FAIL ro_latency got=%0d exp=4", n); end
    total++; if (if_pc !== 32'h100 || if_instr !== (32'h100 ^ XK)) begin bad++; $display("FAIL ro_first got=%h/%h exp=100/%h", if_pc, if_instr, 32'h100 ^ XK); end
  endtask

  task automatic test_simultaneous();
    mem_wait = 0;
    if_ready = 1'b1;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_addr !== 32'h4) begin bad++; $display("FAIL sim_setup got=%h/%h/%h exp=1/0/4", if_valid, if_pc, imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clock);
    redirect = 1'b0;
    total++; if (if_valid !== 1'b0 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin bad++; $display("FAIL sim_flush got=%h/%h/%h exp=0/200/1", if_valid, imem_addr, imem_req); end
    @(negedge clock);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin bad++; $display("FAIL sim_target got=%h/%h exp=1/200", if_valid, if_pc); end
    @(negedge clock);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h204) begin bad++; $display("FAIL sim_no_dup got=%h/%h exp=1/204", if_valid, if_pc); end
  endtask

  task automatic test_wraparound();
    w_rst_n = 1'b1;
    @(negedge clock);
    total++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wr_req got=%h/%h exp=1/fffffff8", w_req, w_addr); end
    @(negedge clock);
    total++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFF8 || w_plus4 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wr_pc0 got=%h/%h/%h exp=1/fffffff8/fffffffc", w_valid, w_pc, w_plus4); end
    @(negedge clock);
    total++; if (w_pc !== 32'hFFFF_FFFC || w_plus4 !== 32'h0) begin bad++; $display("FAIL wr_pc1 got=%h/%h exp=fffffffc/0", w_pc, w_plus4); end
    @(negedge clock);
    total++; if (w_pc !== 32'h0 || w_plus4 !== 32'h4 || w_instr !== XK) begin bad++; $display("FAIL wr_pc2 got=%h/%h/%h exp=0/4/%h", w_pc, w_plus4, w_instr, XK); end
  endtask

  initial begin
    reset_n = 1'b0; if_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    w_rst_n = 1'b0; w_ready = 1'b1; w_redirect = 1'b0; w_redirect_pc = 32'h0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    test_reset();
    test_backpressure();
    test_streaming();
    test_redirect_outstanding();
    test_simultaneous();
    test_wraparound();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
